avalon_st_pkt_arbiter: RTL and testbench
========================================

# avalon_st_pkt_arbiter

Packet-aware round-robin arbiter that merges NUM_SRC Avalon-ST packet sources into one Avalon-ST stream, typically driving the write side of a shared packet FIFO. A grant is locked from the accepted sop beat through the accepted eop beat, so packets are never interleaved. The output is a registered pipeline stage: one beat per cycle, one cycle of latency.

## Interface
Parameters:
- NUM_SRC, default 4: number of input sources; must be at least 2; need not be a power of 2.
- DATA_WIDTH / META_WIDTH: taken from the connected avalon_st_if instances; all inputs and the output share the same values.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- src[NUM_SRC]  avalon_st_if.master  array  input streams; the block drives rdy and receives data, empty, sop, eop and vld.
- dst  avalon_st_if.slave  -  merged output stream; the block drives data, empty, sop, eop and vld, and receives rdy.
- grant_idx  output  $clog2(NUM_SRC)  index of the source currently or most recently granted.
- busy  output  1  high while a packet is in progress (PKT state).

## Operation
- Output stage: the dst fields are registered.
  - adv = ~dst.vld | dst.rdy.
  - A beat is accepted from source i when src[i].vld & src[i].rdy; it loads the dst register on that edge.
- src[i].rdy = adv & (i is the selected source) & ~rst. All non-selected sources see rdy = 0.
- State machine, two states:
  - IDLE:
    - Candidates are sources with vld & sop.
    - Search starts at (last_grant+1) mod NUM_SRC, wraps past NUM_SRC-1 to 0, and selects the first candidate, combinationally in the same cycle.
    - On acceptance of a sop-only beat: cur_src ← sel, go to PKT.
    - On acceptance of a sop & eop beat: last_grant ← sel, stay in IDLE.
    - If adv = 0, nothing is accepted and the selection is re-evaluated next cycle.
  - PKT:
    - Only cur_src is selectable, and its sop is ignored.
    - On acceptance of an eop beat: last_grant ← cur_src, go to IDLE.
    - vld low from cur_src leaves the state unchanged; no other source is served.
- A source presenting vld without sop while not granted is never a candidate. It stalls until it presents sop.
- grant_idx = cur_src in PKT, and last_grant in IDLE.
- Reset values:
  - state = IDLE, last_grant = NUM_SRC-1, so source 0 has first priority.
  - dst.vld = 0, busy = 0, grant_idx = NUM_SRC-1.
  - dst data, empty, sop and eop = 0.
  - All src[i].rdy = 0 while rst is high.

## Timing
- Latency: a beat accepted at edge n is visible on dst from cycle n+1.
- Throughput: 1 beat per cycle with dst.rdy held high, including across packet boundaries.
  - When eop is accepted at edge n, the next packet's sop, from any source, can be accepted at edge n+1.
- Backpressure: if dst.vld = 1 and dst.rdy = 0, the dst register holds all fields and adv = 0.
- Fairness: after a source finishes a packet, every other pending source is served before it is served again.
- Reset mid-packet:
  - The in-flight packet is truncated and the dst register is cleared.
  - The block returns to IDLE with last_grant = NUM_SRC-1.
  - The block does not emit a synthetic eop.
- Simultaneous sop on all sources from reset: serve order is 0, 1, …, NUM_SRC-1, then 0.

## Configuration
- PKT_ARB_SRC_ID_EN defined:
  - Adds an output port src_id [$clog2(NUM_SRC)-1:0].
  - src_id is registered with each accepted beat, holds the index of the source that produced the beat currently on dst, and resets to 0.
- Not defined: the port and its register do not exist, and behaviour is otherwise identical.

## Test plan
- Reset, then sop & eop single-beat packets on src0 and src2 in the same cycle, with dst.rdy = 1:
  - dst shows the src0 beat in cycle 1 and the src2 beat in cycle 2.
  - grant_idx reads 0, then 2.
- src1 sends a 4-beat packet while src0 holds a sop beat throughout:
  - All 4 src1 beats appear contiguously on dst.
  - The src0 packet follows immediately after, with no idle cycle.
  - busy is high for 3 cycles.
- dst.rdy is held low for 3 cycles in the middle of a packet:
  - The dst fields stay stable.
  - All src[i].rdy = 0 during the stall.
  - Beat order is preserved after release.
- Wrap-around with NUM_SRC = 3 and all sources sending continuous single-beat packets:
  - Grant order is 0, 1, 2, 0, 1, 2.
- rst is asserted for 1 cycle after beat 2 of a 5-beat packet:
  - The next cycle shows dst.vld = 0 and busy = 0.
  - A new sop on src0 is then granted first.
- With PKT_ARB_SRC_ID_EN defined, mixed traffic from src3 and src1:
  - src_id matches the originating source on every dst beat.

Source files
------------

// File: rtl/avalon_st_if.sv
// Avalon-ST packet stream bundle. Modport names follow the arbiter's view of
// the link: "master" is an arbiter input (drives rdy), "slave" is its output.
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned META_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] data;
  logic [META_WIDTH-1:0] empty;
  logic                  sop;
  logic                  eop;
  logic                  vld;
  logic                  rdy;

  modport master (input data, empty, sop, eop, vld, output rdy);
  modport slave  (output data, empty, sop, eop, vld, input rdy);
endinterface

// File: rtl/avalon_st_pkt_arbiter.sv
// Packet-locked round-robin merge of NUM_SRC Avalon-ST sources into one
// registered output stage. Optional source tag output: PKT_ARB_SRC_ID_EN.
module avalon_st_pkt_arbiter #(
  parameter  int unsigned NUM_SRC    = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned META_WIDTH = 2,
  localparam int unsigned IW         = $clog2(NUM_SRC)
) (
  input  logic          clk,
  input  logic          rst,
  avalon_st_if.master   src [NUM_SRC],
  avalon_st_if.slave    dst,
  output logic [IW-1:0] grant_idx,
`ifdef PKT_ARB_SRC_ID_EN
  output logic [IW-1:0] src_id,
`endif
  output logic          busy
);

  typedef enum logic {IDLE_S, PKT_S} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         cur_q, cur_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         grant_q;
  logic                  busy_q;

  logic                  dvld_q, dsop_q, deop_q;
  logic [DATA_WIDTH-1:0] ddata_q;
  logic [META_WIDTH-1:0] dempty_q;

  logic [IW-1:0]         sel_c;
  logic                  sel_vld_c, adv_c, acc_c;
  logic [NUM_SRC-1:0]    rdy_c;

  logic [NUM_SRC-1:0]    vld_s, sop_s, eop_s;
  logic [DATA_WIDTH-1:0] data_s  [NUM_SRC];
  logic [META_WIDTH-1:0] empty_s [NUM_SRC];

  // Flatten the interface array so sources can be indexed dynamically
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign vld_s[g]   = src[g].vld;
    assign sop_s[g]   = src[g].sop;
    assign eop_s[g]   = src[g].eop;
    assign data_s[g]  = src[g].data;
    assign empty_s[g] = src[g].empty;
    assign src[g].rdy = rdy_c[g];
  end

  // Source selection, handshake and next-state logic
  always_comb begin : comb_p
    int unsigned   sum;
    logic [IW-1:0] idx;
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    sel_c     = '0;
    sel_vld_c = 1'b0;
    rdy_c     = '0;
    acc_c     = 1'b0;
    sum       = '0;
    idx       = '0;
    adv_c     = ~dvld_q | dst.rdy;

    if (state_q == PKT_S) begin
      sel_c     = cur_q;
      sel_vld_c = 1'b1;
    end else begin
      // Scan upward from last_grant+1 with wrap; offsets never exceed 2*NUM_SRC-1
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
        sum = 32'(last_q) + k;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        idx = IW'(sum);
        if (!sel_vld_c && vld_s[idx] && sop_s[idx]) begin
          sel_vld_c = 1'b1;
          sel_c     = idx;
        end
      end
    end

    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      rdy_c[i] = adv_c & sel_vld_c & ~rst & (sel_c == IW'(i));
    end
    acc_c = adv_c & sel_vld_c & ~rst & vld_s[sel_c];

    case (state_q)
      IDLE_S: begin
        if (acc_c) begin
          if (eop_s[sel_c]) begin
            last_d = sel_c;
          end else begin
            cur_d   = sel_c;
            state_d = PKT_S;
          end
        end
      end
      PKT_S: begin
        if (acc_c && eop_s[cur_q]) begin
          last_d  = cur_q;
          state_d = IDLE_S;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // State, grant bookkeeping and output stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE_S;
      cur_q    <= '0;
      last_q   <= IW'(NUM_SRC - 1);
      grant_q  <= IW'(NUM_SRC - 1);
      busy_q   <= 1'b0;
      dvld_q   <= 1'b0;
      dsop_q   <= 1'b0;
      deop_q   <= 1'b0;
      ddata_q  <= '0;
      dempty_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      grant_q <= (state_d == PKT_S) ? cur_d : last_d;
      busy_q  <= (state_d == PKT_S);
      if (acc_c) begin
        dvld_q   <= 1'b1;
        dsop_q   <= sop_s[sel_c];
        deop_q   <= eop_s[sel_c];
        ddata_q  <= data_s[sel_c];
        dempty_q <= empty_s[sel_c];
      end else if (dst.rdy) begin
        dvld_q <= 1'b0;
      end
    end
  end

`ifdef PKT_ARB_SRC_ID_EN
  logic [IW-1:0] src_id_q;

  // Tag travels with the beat into the output register
  always_ff @(posedge clk) begin
    if (rst)        src_id_q <= '0;
    else if (acc_c) src_id_q <= sel_c;
  end

  assign src_id = src_id_q;
`else
  // Untagged build: output beats carry no source index
`endif

  assign dst.vld   = dvld_q;
  assign dst.sop   = dsop_q;
  assign dst.eop   = deop_q;
  assign dst.data  = ddata_q;
  assign dst.empty = dempty_q;
  assign grant_idx = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// Self-checking bench: per-cycle reference model of the packet arbiter plus
// directed scenarios pinned with literal expectations, then random traffic.
module tb_avalon_st_pkt_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 2;
  localparam int unsigned IW = $clog2(N);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [MW-1:0] empty;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] grant;
    logic          busy;
    int            cyc;
  } log_t;

  logic clk;
  logic rst;
  logic [N-1:0]  b_vld, b_sop, b_eop, b_rdy;
  logic [DW-1:0] b_data  [N];
  logic [MW-1:0] b_empty [N];
  logic          b_dst_rdy;
  logic [IW-1:0] grant_idx;
  logic          busy;
`ifdef PKT_ARB_SRC_ID_EN
  logic [IW-1:0] src_id;
`endif

  avalon_st_if #(.DATA_WIDTH(DW), .META_WIDTH(MW)) src_if [N] ();
  avalon_st_if #(.DATA_WIDTH(DW), .META_WIDTH(MW)) dst_if ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign src_if[g].vld   = b_vld[g];
    assign src_if[g].sop   = b_sop[g];
    assign src_if[g].eop   = b_eop[g];
    assign src_if[g].data  = b_data[g];
    assign src_if[g].empty = b_empty[g];
    assign b_rdy[g]        = src_if[g].rdy;
  end
  assign dst_if.rdy = b_dst_rdy;

  avalon_st_pkt_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .META_WIDTH(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src_if),
    .dst       (dst_if),
    .grant_idx (grant_idx),
`ifdef PKT_ARB_SRC_ID_EN
    .src_id    (src_id),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int serial = 0;

  beat_t sq [N][$];
  log_t  lg [$];

  bit rst_req;
  int rdy_mode;
  int vld_pct;
  logic o_vld, o_busy;

  // Reference model: who owns the output, who was served last, what dst shows
  bit            m_pkt;
  int            m_cur, m_last;
  logic          e_vld, e_sop, e_eop;
  logic [DW-1:0] e_data;
  logic [MW-1:0] e_empty;
  int            e_src;

  function void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic logic [DW-1:0] mk_data(input int s, input int ser, input int b);
    return {2'(s), 10'(ser), 4'(b)};
  endfunction

  function automatic int push_pkt(input int s, input int len);
    int ser = serial;
    beat_t bt;
    serial++;
    for (int b = 0; b < len; b++) begin
      bt.data  = mk_data(s, ser, b);
      bt.empty = (b == len - 1) ? MW'($urandom) : '0;
      bt.sop   = (b == 0);
      bt.eop   = (b == len - 1);
      sq[s].push_back(bt);
    end
    return ser;
  endfunction

  task automatic model_edge();
    int sel = -1;
    bit adv = !e_vld || b_dst_rdy;
    int i;
    if (!rst) begin
      if (m_pkt) sel = m_cur;
      else
        for (int k = 1; k <= int'(N); k++) begin
          i = (m_last + k) % int'(N);
          if (sel < 0 && b_vld[i] && b_sop[i]) sel = i;
        end
    end
    for (int j = 0; j < int'(N); j++)
      chk($sformatf("src%0d_rdy", j), 64'(b_rdy[j]), 64'(adv && sel == j && !rst));
    if (rst) begin
      m_pkt = 0; m_cur = 0; m_last = N - 1;
      e_vld = 0; e_sop = 0; e_eop = 0; e_data = '0; e_empty = '0; e_src = 0;
      for (int j = 0; j < int'(N); j++) sq[j].delete();
    end else if (sel >= 0 && adv && b_vld[sel]) begin
      e_vld = 1; e_sop = b_sop[sel]; e_eop = b_eop[sel];
      e_data = b_data[sel]; e_empty = b_empty[sel]; e_src = sel;
      void'(sq[sel].pop_front());
      if (m_pkt) begin
        if (b_eop[sel]) begin m_last = m_cur; m_pkt = 0; end
      end else if (b_eop[sel]) m_last = sel;
      else begin m_cur = sel; m_pkt = 1; end
    end else if (b_dst_rdy) begin
      e_vld = 0;
    end
  endtask

  // One clock: compare outputs, drive next inputs, check rdy, advance model
  task automatic step();
    beat_t hd;
    @(negedge clk);
    cyc++;
    chk("dst_vld",   64'(dst_if.vld),   64'(e_vld));
    chk("dst_data",  64'(dst_if.data),  64'(e_data));
    chk("dst_empty", 64'(dst_if.empty), 64'(e_empty));
    chk("dst_sop",   64'(dst_if.sop),   64'(e_sop));
    chk("dst_eop",   64'(dst_if.eop),   64'(e_eop));
    chk("grant_idx", 64'(grant_idx),    64'(m_pkt ? m_cur : m_last));
    chk("busy",      64'(busy),         64'(m_pkt));
`ifdef PKT_ARB_SRC_ID_EN
    chk("src_id",    64'(src_id),       64'(e_src));
`endif
    o_vld  = dst_if.vld;
    o_busy = busy;
    rst = rst_req;
    b_dst_rdy = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(99) < 75);
    for (int i = 0; i < int'(N); i++) begin
      if (sq[i].size() > 0 && $urandom_range(99) < 32'(vld_pct)) begin
        hd = sq[i][0];
        b_vld[i] = 1'b1; b_data[i] = hd.data; b_empty[i] = hd.empty;
        b_sop[i] = hd.sop; b_eop[i] = hd.eop;
      end else begin
        b_vld[i] = 1'b0; b_data[i] = DW'($urandom); b_empty[i] = MW'($urandom);
        b_sop[i] = 1'($urandom_range(1)); b_eop[i] = 1'($urandom_range(1));
      end
    end
    if (dst_if.vld && b_dst_rdy)
      lg.push_back('{data: dst_if.data, grant: grant_idx, busy: busy, cyc: cyc});
    #1;
    model_edge();
  endtask

  task automatic run_until(input int n, input int budget, input string nm);
    int k = 0;
    while (lg.size() < n && k < budget) begin step(); k++; end
    chk(nm, 64'(lg.size() >= n), 64'(1));
  endtask

  int s0, s1, s2, bsum;
  logic [DW-1:0] hold;

  initial begin
    rst = 1'b1; rst_req = 1'b1; rdy_mode = 1; vld_pct = 100;
    b_vld = '0; b_sop = '0; b_eop = '0; b_dst_rdy = 1'b1;
    for (int i = 0; i < int'(N); i++) begin b_data[i] = '0; b_empty[i] = '0; end
    m_pkt = 0; m_cur = 0; m_last = N - 1;
    e_vld = 0; e_sop = 0; e_eop = 0; e_data = '0; e_empty = '0; e_src = 0;

    step(); step();
    rst_req = 1'b0;
    step();
    chk("rst_dst_vld", 64'(dst_if.vld), 64'(0));
    chk("rst_grant",   64'(grant_idx),  64'(N - 1));
    chk("rst_busy",    64'(busy),       64'(0));

    // Single-beat packets on src0 and src2 together
    lg.delete();
    s0 = push_pkt(0, 1);
    s2 = push_pkt(2, 1);
    run_until(2, 20, "t1_wait");
    chk("t1_first",  64'(lg[0].data),  64'(mk_data(0, s0, 0)));
    chk("t1_second", 64'(lg[1].data),  64'(mk_data(2, s2, 0)));
    chk("t1_grant0", 64'(lg[0].grant), 64'(0));
    chk("t1_grant1", 64'(lg[1].grant), 64'(2));
    chk("t1_b2b",    64'(lg[1].cyc - lg[0].cyc), 64'(1));

    // src1 4-beat packet locks out a waiting src0 sop
    lg.delete();
    void'(push_pkt(0, 1));
    run_until(1, 20, "t2_pre");
    lg.delete();
    s1 = push_pkt(1, 4);
    s0 = push_pkt(0, 1);
    run_until(5, 30, "t2_wait");
    bsum = 0;
    for (int b = 0; b < 4; b++) begin
      chk("t2_src1_beat", 64'(lg[b].data), 64'(mk_data(1, s1, b)));
      bsum += int'(lg[b].busy);
    end
    chk("t2_src0_after", 64'(lg[4].data), 64'(mk_data(0, s0, 0)));
    chk("t2_no_gap",     64'(lg[4].cyc - lg[0].cyc), 64'(4));
    chk("t2_busy_cnt",   64'(bsum + int'(lg[4].busy)), 64'(3));

    // Three-cycle output stall in the middle of a src2 packet
    lg.delete();
    s2 = push_pkt(2, 5);
    run_until(2, 20, "t3_pre");
    rdy_mode = 0;
    step();
    hold = dst_if.data;
    chk("t3_hold_beat", 64'(hold), 64'(mk_data(2, s2, 2)));
    chk("t3_src_rdy",   64'(b_rdy), 64'(0));
    repeat (2) begin
      step();
      chk("t3_hold", 64'(dst_if.data), 64'(hold));
      chk("t3_src_rdy", 64'(b_rdy), 64'(0));
    end
    rdy_mode = 1;
    run_until(5, 30, "t3_wait");
    for (int b = 0; b < 5; b++)
      chk("t3_order", 64'(lg[b].data), 64'(mk_data(2, s2, b)));

    // Continuous single-beat packets on every source: strict rotation
    lg.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < int'(N); i++) void'(push_pkt(i, 1));
    run_until(6, 30, "t4_wait");
    for (int k = 0; k < 6; k++) begin
      chk("t4_src",   64'(lg[k].data[DW-1 -: 2]), 64'(k % 3));
      chk("t4_grant", 64'(lg[k].grant),           64'(k % 3));
    end

    // Reset mid-packet restores source 0 priority
    lg.delete();
    void'(push_pkt(0, 1));
    run_until(1, 20, "t5_pre");
    lg.delete();
    void'(push_pkt(1, 5));
    run_until(2, 20, "t5_mid");
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk("t5_vld",  64'(o_vld),  64'(0));
    chk("t5_busy", 64'(o_busy), 64'(0));
    lg.delete();
    s1 = push_pkt(1, 1);
    s0 = push_pkt(0, 1);
    run_until(2, 20, "t5_wait");
    chk("t5_first",  64'(lg[0].data), 64'(mk_data(0, s0, 0)));
    chk("t5_second", 64'(lg[1].data), 64'(mk_data(1, s1, 0)));

    // Random traffic, gaps, backpressure and occasional reset
    rdy_mode = 2;
    vld_pct  = 70;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++)
        if (sq[i].size() < 3) void'(push_pkt(i, int'($urandom_range(1, 5))));
      rst_req = ($urandom_range(999) < 3);
      step();
    end
    rst_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
